// File: rtl/bcd_conv_arbiter.sv
// Shares one iterative binary-to-BCD converter among NUM_REQ requesters.
// Define BCD_ARB_RR_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module bcd_conv_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int INPUT_WIDTH    = 8,
  parameter int DECIMAL_DIGITS = 3,
  parameter int DRAIN_CYCLES   = 128
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_L,
  input  logic [NUM_REQ-1:0]            i_Req,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] i_Binary,
  output logic [NUM_REQ-1:0]            o_Grant,
  output logic [NUM_REQ-1:0]            o_Done,
  output logic [DECIMAL_DIGITS*4-1:0]   o_BCD,
  output logic                          o_Busy,
  output logic                          o_Conv_Start,
  output logic [INPUT_WIDTH-1:0]        o_Conv_Binary,
  input  logic [DECIMAL_DIGITS*4-1:0]   i_Conv_BCD,
  input  logic                          i_Conv_DV,
  output logic [2:0]                    o_State
);

  // Converter handshake: o_Conv_Start is a one-cycle strobe with o_Conv_Binary
  // already stable; o_Conv_Binary is held until the converter raises i_Conv_DV
  // for one cycle with i_Conv_BCD valid in that same cycle.

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_DRAIN = 3'd0,
    S_IDLE  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [7:0]             drain_cnt;
  logic [IDXW-1:0]        win_idx;
  logic [IDXW-1:0]        cand;
  logic [INPUT_WIDTH-1:0] win_bin;
  logic                   grant_now;

  assign o_Busy    = (state != S_IDLE);
  assign o_State   = state;
  assign grant_now = (state == S_IDLE) && (|i_Req);

`ifdef BCD_ARB_RR_EN
  logic [IDXW-1:0] rr_ptr;

  // Search upward from the slot after the last winner; lowest offset wins.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDXW'((int'(rr_ptr) + k) % NUM_REQ);
      if (i_Req[cand]) win_idx = cand;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) rr_ptr <= '0;
    else if (grant_now) rr_ptr <= win_idx;
  end
`else
  always_comb begin
    win_idx = '0;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDXW'(i);
      if (i_Req[cand]) win_idx = cand;
    end
  end
`endif

  always_comb begin
    win_bin = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDXW'(i)) win_bin = i_Binary[i*INPUT_WIDTH +: INPUT_WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_DRAIN: if (i_Conv_DV || drain_cnt <= 8'd1) state_nxt = S_IDLE;
      S_IDLE:  if (|i_Req) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (i_Conv_DV) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_DRAIN;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state         <= S_DRAIN;
      drain_cnt     <= 8'(DRAIN_CYCLES);
      o_Grant       <= '0;
      o_Done        <= '0;
      o_BCD         <= '0;
      o_Conv_Start  <= 1'b0;
      o_Conv_Binary <= '0;
    end else begin
      state        <= state_nxt;
      o_Conv_Start <= grant_now;
      o_Done       <= '0;
      if (state == S_DRAIN) drain_cnt <= drain_cnt - 8'd1;
      if (grant_now) begin
        o_Grant       <= NUM_REQ'(1) << win_idx;
        o_Conv_Binary <= win_bin;
      end
      // A data-valid outside WAIT belongs to nobody and is dropped.
      if (state == S_WAIT && i_Conv_DV) begin
        o_BCD  <= i_Conv_BCD;
        o_Done <= o_Grant;
      end
      if (state == S_DONE) o_Grant <= '0;
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: converter model, behavioural reference, per-cycle compare and result scoreboard.
module tb_bcd_conv_arbiter;
  localparam int NR = 4;
  localparam int IW = 8;
  localparam int DD = 3;
  localparam int DRAIN = 128;

  localparam int P_DRAIN = 0;
  localparam int P_IDLE  = 1;
  localparam int P_START = 2;
  localparam int P_WAIT  = 3;
  localparam int P_DONE  = 4;

  logic              clk;
  logic              i_Rst_L;
  logic [NR-1:0]     i_Req;
  logic [NR*IW-1:0]  i_Binary;
  logic [NR-1:0]     o_Grant;
  logic [NR-1:0]     o_Done;
  logic [DD*4-1:0]   o_BCD;
  logic              o_Busy;
  logic              o_Conv_Start;
  logic [IW-1:0]     o_Conv_Binary;
  logic [DD*4-1:0]   i_Conv_BCD;
  logic              i_Conv_DV;
  logic [2:0]        dbg_state;

  int checks = 0;
  int failures = 0;

  bcd_conv_arbiter #(
    .NUM_REQ(NR), .INPUT_WIDTH(IW), .DECIMAL_DIGITS(DD), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .i_Clock(clk), .i_Rst_L(i_Rst_L), .i_Req(i_Req), .i_Binary(i_Binary),
    .o_Grant(o_Grant), .o_Done(o_Done), .o_BCD(o_BCD), .o_Busy(o_Busy),
    .o_Conv_Start(o_Conv_Start), .o_Conv_Binary(o_Conv_Binary),
    .i_Conv_BCD(i_Conv_BCD), .i_Conv_DV(i_Conv_DV), .o_State(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DD*4-1:0] to_bcd(input int value);
    logic [DD*4-1:0] b;
    int v;
    b = '0;
    v = value;
    for (int d = 0; d < DD; d++) begin
      b = b | ((DD*4)'(v % 10) << (4 * d));
      v = v / 10;
    end
    return b;
  endfunction

  function automatic int pick(input logic [NR-1:0] r, input int last);
`ifdef BCD_ARB_RR_EN
    for (int k = 1; k <= NR; k++) begin
      if (((r >> ((last + k) % NR)) & 1) != 0) return (last + k) % NR;
    end
`else
    for (int i = 0; i < NR; i++) begin
      if (((r >> i) & 1) != 0) return i;
    end
`endif
    return -1;
  endfunction

  // ---------------- converter model (no reset, like the real block) ----------------
  logic          inject_dv = 1'b0;
  int            lat_fix = 0;
  int            conv_cnt = 0;
  logic [IW-1:0] conv_op = '0;

  initial begin
    i_Conv_DV  = 1'b0;
    i_Conv_BCD = '0;
  end

  always begin
    @(negedge clk);
    #1;
    i_Conv_DV  = 1'b0;
    i_Conv_BCD = (DD*4)'($urandom);
    if (inject_dv) begin
      i_Conv_DV  = 1'b1;
      i_Conv_BCD = 12'h999;
      inject_dv  = 1'b0;
    end else if (conv_cnt > 0) begin
      conv_cnt--;
      if (conv_cnt == 0) begin
        i_Conv_DV  = 1'b1;
        i_Conv_BCD = to_bcd(int'(conv_op));
      end
    end
    if (o_Conv_Start) begin
      conv_op  = o_Conv_Binary;
      conv_cnt = (lat_fix != 0) ? lat_fix : $urandom_range(1, 5);
    end
  end

  // ---------------- reference model ----------------
  int              ph = P_DRAIN;
  int              dcnt = 0;
  int              rr_last = 0;
  int              w;
  logic            m_valid = 1'b0;
  logic [NR-1:0]   m_grant = '0;
  logic [NR-1:0]   m_done = '0;
  logic [DD*4-1:0] m_bcd = '0;
  logic [IW-1:0]   m_bin = '0;
  logic [DD*4-1:0] exp_q[$];

  always @(posedge clk) begin
    if (!i_Rst_L) begin
      ph = P_DRAIN; dcnt = DRAIN; rr_last = 0;
      m_grant = '0; m_done = '0; m_bcd = '0; m_bin = '0;
      exp_q.delete();
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_done = '0;
      case (ph)
        P_DRAIN: begin
          dcnt--;
          if (i_Conv_DV || dcnt == 0) ph = P_IDLE;
        end
        P_IDLE: if (i_Req != 0) begin
          w = pick(i_Req, rr_last);
          rr_last = w;
          m_grant = NR'(1 << w);
          m_bin = IW'(i_Binary >> (w * IW));
          exp_q.push_back(to_bcd(int'(m_bin)));
          ph = P_START;
        end
        P_START: ph = P_WAIT;
        P_WAIT: if (i_Conv_DV) begin
          m_bcd = to_bcd(int'(m_bin));
          m_done = m_grant;
          ph = P_DONE;
        end
        default: begin
          m_grant = '0;
          ph = P_IDLE;
        end
      endcase
    end
  end

  // ---------------- compare + scoreboard ----------------
  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      chk("busy", 32'(o_Busy), 32'(ph != P_IDLE));
      chk("start", 32'(o_Conv_Start), 32'(ph == P_START));
      chk("grant", 32'(o_Grant), 32'(m_grant));
      chk("done", 32'(o_Done), 32'(m_done));
      chk("bcd", 32'(o_BCD), 32'(m_bcd));
      chk("conv_binary", 32'(o_Conv_Binary), 32'(m_bin));
      if (o_Done != 0) begin
        if (exp_q.size() == 0) chk("sb_unexpected_done", 32'(o_Done), 32'd0);
        else chk("sb_result", 32'(o_BCD), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_start();
    int n = 0;
    do begin
      @(posedge clk); #3; n++;
    end while (!o_Conv_Start && n < 400);
    chk("start_seen", 32'(o_Conv_Start), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(posedge clk); #3; n++;
    end while (o_Done == 0 && n < 400);
    chk("done_seen", 32'(o_Done != 0), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk); #3; n++;
    end while (o_Busy && n < 600);
    chk("idle_seen", 32'(o_Busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [NR-1:0]   exp_g[3];
  logic [DD*4-1:0] saved_bcd;
  int              n;

  initial begin
    i_Rst_L = 1'b0; i_Req = '0; i_Binary = '0;
    repeat (2) @(negedge clk);
    i_Rst_L = 1'b1;

    // Drain window: busy for DRAIN-1 edges, idle with cleared result after DRAIN.
    for (int c = 1; c <= DRAIN; c++) begin
      @(posedge clk); #3;
      if (c < DRAIN) chk("drain_busy", 32'(o_Busy), 32'd1);
    end
    chk("drain_exit_busy", 32'(o_Busy), 32'd0);
    chk("drain_bcd", 32'(o_BCD), 32'd0);

    // Single request, operand 255 on requester 1.
    @(negedge clk);
    i_Req = 4'b0010; i_Binary = {8'd0, 8'd0, 8'd255, 8'd0};
    wait_start();
    chk("single_bin", 32'(o_Conv_Binary), 32'h0FF);
    chk("single_grant", 32'(o_Grant), 32'b0010);
    @(negedge clk);
    i_Req = '0;
    @(posedge clk); #3;
    chk("single_start_pulse", 32'(o_Conv_Start), 32'd0);
    wait_done();
    chk("single_bcd", 32'(o_BCD), 32'h255);
    chk("single_done", 32'(o_Done), 32'b0010);

    // Contention with 1011 held.
`ifdef BCD_ARB_RR_EN
    exp_g[0] = 4'b1000; exp_g[1] = 4'b0001; exp_g[2] = 4'b0010;
`else
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0001; exp_g[2] = 4'b0001;
`endif
    @(negedge clk);
    i_Req = 4'b1011; i_Binary = 32'($urandom);
    for (int g = 0; g < 3; g++) begin
      wait_start();
      chk("contention_grant", 32'(o_Grant), 32'(exp_g[g]));
    end
    @(negedge clk);
    i_Req = '0;
    wait_done();

    // Operand changes during WAIT must not matter.
    @(negedge clk);
    i_Req = 4'b0100; i_Binary = {8'd0, 8'd99, 8'd0, 8'd0};
    wait_start();
    @(negedge clk);
    i_Req = '0; i_Binary = {8'd0, 8'd7, 8'd0, 8'd0};
    wait_done();
    chk("operand_hold_bcd", 32'(o_BCD), 32'h099);

    // Stray data-valid in IDLE.
    repeat (2) @(negedge clk);
    saved_bcd = o_BCD;
    inject_dv = 1'b1;
    @(posedge clk); #3;
    chk("stray_dv_bcd", 32'(o_BCD), 32'(saved_bcd));
    chk("stray_dv_done", 32'(o_Done), 32'd0);
    chk("stray_dv_busy", 32'(o_Busy), 32'd0);

    // Reset during WAIT; the late data-valid lands in DRAIN.
    lat_fix = 8;
    @(negedge clk);
    i_Req = 4'b0001; i_Binary = 32'($urandom);
    wait_start();
    @(negedge clk);
    i_Req = '0;
    @(negedge clk);
    i_Rst_L = 1'b0;
    @(negedge clk);
    i_Rst_L = 1'b1;
    lat_fix = 0;
    n = 0;
    do begin
      @(negedge clk); #2; n++;
    end while (!i_Conv_DV && n < 20);
    chk("late_dv_seen", 32'(i_Conv_DV), 32'd1);
    @(posedge clk); #3;
    chk("late_dv_idle", 32'(o_Busy), 32'd0);
    chk("late_dv_bcd", 32'(o_BCD), 32'd0);
    chk("late_dv_done", 32'(o_Done), 32'd0);

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) i_Req = NR'($urandom);
      i_Binary = 32'($urandom);
      i_Rst_L = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    i_Rst_L = 1'b1; i_Req = '0;
    wait_idle();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
